// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator and its prescaler.
package led_pkg;

    // Pattern modes as presented on the mode input.
    typedef enum logic [1:0] {
        BLINK  = 2'd0,
        COUNT  = 2'd1,
        CHASE  = 2'd2,
        BOUNCE = 2'd3
    } led_mode_t;

    // Travel direction of the lit LED in BOUNCE.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_t;

    // Prescaler counter width: enough bits to hold 0..d-1, never less than one.
    function automatic int div_w(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Step-tick prescaler: emits a one-cycle tick every DIV enabled clock cycles.
// Kept separate so other blocks can share the same step tick.
module tick_divider
    import led_pkg::*;
#(
    parameter int DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            W    = div_w(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    // Count enabled cycles; wrap and pulse tick on the last one, freeze when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            if (div_cnt == LAST) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick drives a mode FSM that advances
// an N_LEDS-bit pattern (blink, binary count, chase, bounce).
// Optional brightness PWM gating is built when LED_PWM_EN is defined.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LEDS   = 5,
    parameter int DIV      = 12000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic                tick,
    output logic [N_LEDS-1:0]   led
`ifdef LED_PWM_EN
    ,
    input  logic [PWM_BITS-1:0] brightness
`endif
);

    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] MSB = ONE << (N_LEDS - 1);

    led_mode_t          cur_mode, mode_nx, req_mode;
    led_dir_t           dir, dir_nx;
    logic [N_LEDS-1:0]  pattern, pat_nx, pattern_out, led_q;
    logic               tick_d;
    logic               is_onehot;

    assign req_mode  = led_mode_t'(mode);
    assign is_onehot = (pattern != '0) && ((pattern & (pattern - ONE)) == '0);

    // In BLINK the top LED runs in anti-phase with the others.
    assign pattern_out = (cur_mode == BLINK) ? (pattern ^ MSB) : pattern;

    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Mode / pattern / direction state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_mode <= BLINK;
            pattern  <= '0;
            dir      <= DIR_UP;
        end else begin
            cur_mode <= mode_nx;
            pattern  <= pat_nx;
            dir      <= dir_nx;
        end
    end

    // Next-state: a mode change on a tick loads the start pattern, otherwise advance.
    always_comb begin
        mode_nx = cur_mode;
        pat_nx  = pattern;
        dir_nx  = dir;
        if (tick) begin
            if (req_mode != cur_mode) begin
                mode_nx = req_mode;
                dir_nx  = DIR_UP;
                case (req_mode)
                    BLINK:   pat_nx = '1;
                    COUNT:   pat_nx = '0;
                    CHASE:   pat_nx = ONE;
                    BOUNCE:  pat_nx = ONE;
                    default: pat_nx = '0;
                endcase
            end else begin
                case (cur_mode)
                    BLINK: pat_nx = ~pattern;
                    COUNT: pat_nx = pattern + ONE;
                    CHASE: begin
                        if (!is_onehot) pat_nx = ONE;
                        else            pat_nx = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                    end
                    BOUNCE: begin
                        if (!is_onehot) begin
                            pat_nx = ONE;
                            dir_nx = DIR_UP;
                        end else if (dir == DIR_UP) begin
                            if (pattern[N_LEDS-1]) begin
                                // Already at the top end: turn around rather than drop the bit.
                                pat_nx = pattern >> 1;
                                dir_nx = DIR_DOWN;
                            end else begin
                                pat_nx = pattern << 1;
                                if (pat_nx[N_LEDS-1]) dir_nx = DIR_DOWN;
                            end
                        end else begin
                            if (pattern[0]) begin
                                pat_nx = pattern << 1;
                                dir_nx = DIR_UP;
                            end else begin
                                pat_nx = pattern >> 1;
                                if (pat_nx[0]) dir_nx = DIR_UP;
                            end
                        end
                    end
                    default: pat_nx = pattern;
                endcase
            end
        end
    end

    // Output register: capture the pattern one cycle after each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_d <= 1'b0;
            led_q  <= '0;
        end else begin
            tick_d <= tick;
            if (tick_d) led_q <= pattern_out;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    // Free-running brightness counter, independent of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign led = led_q & {N_LEDS{pwm_cnt < brightness}};
`else
    assign led = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_LEDS=5, DIV=4) with an expected-LED queue.
module tb_led_pattern_gen;

    localparam int N = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         tick;
    logic [N-1:0] led;
`ifdef LED_PWM_EN
    logic [3:0]   brightness;
`endif

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LEDS(N), .DIV(D), .PWM_BITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .tick (tick),
        .led  (led)
`ifdef LED_PWM_EN
        ,
        .brightness (brightness)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a tick; n = negedges elapsed until tick seen.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 64);
        if (!tick) chk("tick_timeout", {31'b0, tick}, 32'd1);
    endtask

    // LED settles two edges after the tick cycle is seen.
    task automatic check_led(input string tag);
        logic [N-1:0] e;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("queue_empty", exp_q.size(), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {27'b0, led}, {27'b0, e});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        while (exp_q.size() > 0) begin
            wait_tick(n);
            check_led(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'd0;
`ifdef LED_PWM_EN
        brightness = 4'd15;
`endif
        repeat (2) @(negedge clk);
        chk("rst_led", {27'b0, led}, 32'd0);
        chk("rst_tick", {31'b0, tick}, 32'd0);

        // BLINK from reset: first tick D cycles after release, then alternate.
        rst = 1'b0;
        en  = 1'b1;
        wait_tick(n);
        chk("first_tick_lat", n, D);
        chk("led_pre_tick", {27'b0, led}, 32'd0);
        exp_q.push_back(5'b01111);
        check_led("blink0");
        wait_tick(n);
        chk("tick_period", n, 2);
        @(negedge clk);
        chk("tick_width", {31'b0, tick}, 32'd0);
        @(negedge clk);
        chk("blink1", {27'b0, led}, {27'b0, 5'b10000});
        exp_q.push_back(5'b01111);
        exp_q.push_back(5'b10000);
        drain("blink");

        // CHASE: mode change tick loads bit 0, then rotate with wrap.
        mode = 2'd2;
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b00001);
        drain("chase");

        // CHASE -> COUNT between ticks: nothing changes until the next tick.
        mode = 2'd1;
        @(negedge clk);
        chk("mode_hold", {27'b0, led}, 32'd1);
        for (int i = 0; i <= 5; i++) exp_q.push_back(N'(i));
        drain("count");

        // Freeze for 10 cycles with prescaler at 2; resume from that phase.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_low_tick", {31'b0, tick}, 32'd0);
            chk("en_low_led", {27'b0, led}, 32'd5);
        end
        en = 1'b1;
        wait_tick(n);
        chk("resume_phase", n, 2);
        exp_q.push_back(5'd6);
        check_led("count_resume");
        for (int i = 7; i <= 31; i++) exp_q.push_back(N'(i));
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd1);
        drain("count_wrap");

        // BOUNCE: end bits dwell exactly one tick.
        mode = 2'd3;
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b01000);
        exp_q.push_back(5'b00100);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00010);
        drain("bounce");

        // Asynchronous reset mid-cycle during CHASE.
        mode = 2'd2;
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00010);
        drain("chase2");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", {27'b0, led}, 32'd0);
        chk("async_rst_tick", {31'b0, tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        chk("rst_first_tick", n, D);
        exp_q.push_back(5'b00001);
        check_led("chase_after_rst");
        exp_q.push_back(5'b00010);
        drain("chase_after_rst");

`ifdef LED_PWM_EN
        // Frozen pattern, brightness 4 of 16: lit LED high 4 of 16 cycles.
        en = 1'b0;
        brightness = 4'd4;
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led[1]) hi++;
        end
        chk("pwm_duty", hi, 4);
`else
        hi = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
